// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ packet sources.
// The grant is held for a whole packet, so packets never interleave in the FIFO.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 8,
    localparam int FIFO_WIDTH = ID_WIDTH + DATA_WIDTH + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [FIFO_WIDTH-1:0]         fifo_din,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [15:0]                   pkt_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] next_id;
    logic [ID_WIDTH-1:0] search_idx;
    logic                found;
    logic                last_beat;

    // First valid requester at or above rr_ptr; index arithmetic wraps because NUM_REQ is a power of two.
    always_comb begin
        next_id    = rr_ptr;
        search_idx = rr_ptr;
        found      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            search_idx = rr_ptr + ID_WIDTH'(k);
            if (!found && req_valid[search_idx]) begin
                found   = 1'b1;
                next_id = search_idx;
            end
        end
    end

    // fifo_full gates the handshake combinationally so a write is never attempted into a full FIFO.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        if (state == BURST) begin
            req_ready[grant_id] = ~fifo_full;
            fifo_wr_en          = req_valid[grant_id] & ~fifo_full;
            fifo_din            = {grant_id,
                                   req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH],
                                   req_last[grant_id]};
        end
    end

    assign last_beat = fifo_wr_en & req_last[grant_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            grant_id  <= '0;
            pkt_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= BURST;
                        busy     <= 1'b1;
                        grant_id <= next_id;
                    end
                end
                BURST: begin
                    if (last_beat) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        rr_ptr    <= grant_id + 1'b1;
                        pkt_count <= pkt_count + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table plus hand-built
// sequences for stalls, fairness, mid-burst reset and counter wrap.
module tb_fifo_wr_arbiter;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  ready;
        logic        wr_en;
        logic [10:0] din;
        logic        busy;
        logic [1:0]  grant;
        logic [15:0] pkt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [10:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] pkt_count;

    int check_count = 0;
    int pass_count  = 0;
    int write_count = 0;

    vec_t tbl[16];

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .ID_WIDTH  (2),
        .DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_din  (fifo_din),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full (fifo_full),
        .busy      (busy),
        .grant_id  (grant_id),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && fifo_wr_en) write_count <= write_count + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                                input logic f, input logic [3:0] r, input logic we,
                                input logic [10:0] dn, input logic b, input logic [1:0] g,
                                input logic [15:0] p);
        vec_t x;
        x.valid = v; x.data = d; x.last = l; x.full = f;
        x.ready = r; x.wr_en = we; x.din = dn; x.busy = b; x.grant = g; x.pkt = p;
        return x;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic check_output(input vec_t e, input string name);
        compare({name, " ready"}, 32'(req_ready), 32'(e.ready));
        compare({name, " wr_en"}, 32'(fifo_wr_en), 32'(e.wr_en));
        compare({name, " din"}, 32'(fifo_din), 32'(e.din));
        compare({name, " busy"}, 32'(busy), 32'(e.busy));
        compare({name, " pkt"}, 32'(pkt_count), 32'(e.pkt));
        if (e.busy) compare({name, " grant"}, 32'(grant_id), 32'(e.grant));
    endtask

    task automatic drive_check(input vec_t e, input string name);
        req_valid = e.valid;
        req_data  = e.data;
        req_last  = e.last;
        fifo_full = e.full;
        #1;
        check_output(e, name);
    endtask

    task automatic apply_stimulus(input vec_t e, input string name);
        @(negedge clk);
        drive_check(e, name);
    endtask

    initial begin
        // din = {id, data, last}: id*0x200 + data*2 + last
        tbl[0]  = mk(4'hF, 32'h13121110, 4'hF, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd0);
        tbl[1]  = mk(4'hF, 32'h13121110, 4'hF, 0, 4'h1, 1, 11'h021, 1, 2'd0, 16'd0);
        tbl[2]  = mk(4'hE, 32'h13121110, 4'hF, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd1);
        tbl[3]  = mk(4'hE, 32'h13121110, 4'hF, 0, 4'h2, 1, 11'h223, 1, 2'd1, 16'd1);
        tbl[4]  = mk(4'hC, 32'h13121110, 4'hF, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd2);
        tbl[5]  = mk(4'hC, 32'h13121110, 4'hF, 0, 4'h4, 1, 11'h425, 1, 2'd2, 16'd2);
        tbl[6]  = mk(4'h8, 32'h13121110, 4'hF, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd3);
        tbl[7]  = mk(4'h8, 32'h13121110, 4'hF, 0, 4'h8, 1, 11'h627, 1, 2'd3, 16'd3);
        tbl[8]  = mk(4'h0, 32'h00000000, 4'h0, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd4);
        tbl[9]  = mk(4'h6, 32'h0055A000, 4'h4, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd4);
        tbl[10] = mk(4'h6, 32'h0055A000, 4'h4, 0, 4'h2, 1, 11'h340, 1, 2'd1, 16'd4);
        tbl[11] = mk(4'h6, 32'h0055A100, 4'h4, 0, 4'h2, 1, 11'h342, 1, 2'd1, 16'd4);
        tbl[12] = mk(4'h6, 32'h0055A200, 4'h6, 0, 4'h2, 1, 11'h345, 1, 2'd1, 16'd4);
        tbl[13] = mk(4'h4, 32'h00550000, 4'h4, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd5);
        tbl[14] = mk(4'h4, 32'h00550000, 4'h4, 0, 4'h4, 1, 11'h4AB, 1, 2'd2, 16'd5);
        tbl[15] = mk(4'h0, 32'h00000000, 4'h0, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd6);

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        #12;
        check_output(mk(4'h0, 0, 4'h0, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd0), "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset ordering and packet integrity
        for (int i = 0; i < 16; i++) apply_stimulus(tbl[i], $sformatf("vec%0d", i));

        // Full stall: requester 3, three beats, full for five cycles on beat 2
        apply_stimulus(mk(4'h8, 32'hB0000000, 4'h0, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd6), "stall_idle");
        apply_stimulus(mk(4'h8, 32'hB0000000, 4'h0, 0, 4'h8, 1, 11'h760, 1, 2'd3, 16'd6), "stall_b0");
        for (int i = 0; i < 5; i++)
            apply_stimulus(mk(4'h8, 32'hB1000000, 4'h0, 1, 4'h0, 0, 11'h762, 1, 2'd3, 16'd6),
                           $sformatf("stall_full%0d", i));
        apply_stimulus(mk(4'h8, 32'hB1000000, 4'h0, 0, 4'h8, 1, 11'h762, 1, 2'd3, 16'd6), "stall_b1");
        apply_stimulus(mk(4'h8, 32'hB2000000, 4'h8, 0, 4'h8, 1, 11'h765, 1, 2'd3, 16'd6), "stall_b2");

        // Fairness: requesters 0 and 3 always valid with single-beat packets
        for (int k = 0; k < 8; k++) begin
            logic [1:0]  g;
            logic [10:0] dn;
            g  = (k % 2 == 0) ? 2'd0 : 2'd3;
            dn = (g == 2'd0) ? 11'h089 : 11'h667;
            apply_stimulus(mk(4'h9, 32'h33000044, 4'h9, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'(7 + k)),
                           $sformatf("fair_idle%0d", k));
            apply_stimulus(mk(4'h9, 32'h33000044, 4'h9, 0, 4'(1 << g), 1, dn, 1, g, 16'(7 + k)),
                           $sformatf("fair_grant%0d", k));
        end

        // Mid-burst reset: move rr_ptr to 2, then reset during beat 2 of requester 2
        apply_stimulus(mk(4'h2, 32'h00002200, 4'h2, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd15), "pre_idle");
        apply_stimulus(mk(4'h2, 32'h00002200, 4'h2, 0, 4'h2, 1, 11'h245, 1, 2'd1, 16'd15), "pre_grant");
        apply_stimulus(mk(4'h4, 32'h00C00000, 4'h0, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd16), "mr_idle");
        apply_stimulus(mk(4'h4, 32'h00C00000, 4'h0, 0, 4'h4, 1, 11'h580, 1, 2'd2, 16'd16), "mr_b1");
        apply_stimulus(mk(4'h4, 32'h00C10000, 4'h0, 0, 4'h4, 1, 11'h582, 1, 2'd2, 16'd16), "mr_b2");
        #1;
        rst_n = 1'b0;
        #1;
        check_output(mk(4'h4, 32'h00C10000, 4'h0, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd0), "mr_async");
        @(negedge clk);
        rst_n = 1'b1;
        drive_check(mk(4'hA, 32'h33003100, 4'hA, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd0), "mr_rel_idle");
        apply_stimulus(mk(4'hA, 32'h33003100, 4'hA, 0, 4'h2, 1, 11'h263, 1, 2'd1, 16'd0), "mr_rel_grant");
        apply_stimulus(mk(4'h0, 32'h00000000, 4'h0, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'd1), "mr_done");

        // Counter wrap: preload near the top, then two single-beat packets
        force dut.pkt_count = 16'hFFFE;
        #1;
        release dut.pkt_count;
        apply_stimulus(mk(4'h1, 32'h00000077, 4'h1, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'hFFFE), "wrap_idle0");
        apply_stimulus(mk(4'h1, 32'h00000077, 4'h1, 0, 4'h1, 1, 11'h0EF, 1, 2'd0, 16'hFFFE), "wrap_pkt0");
        apply_stimulus(mk(4'h1, 32'h00000077, 4'h1, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'hFFFF), "wrap_idle1");
        apply_stimulus(mk(4'h1, 32'h00000077, 4'h1, 0, 4'h1, 1, 11'h0EF, 1, 2'd0, 16'hFFFF), "wrap_pkt1");
        apply_stimulus(mk(4'h0, 32'h00000000, 4'h0, 0, 4'h0, 0, 11'h000, 0, 2'd0, 16'h0000), "wrap_zero");

        // Total beats written: 4 + 4 + 3 + 8 + 1 + 1 + 1 + 2
        compare("write_total", 32'(write_count), 32'd24);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
